param_sync_fifo: RTL and testbench

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. It is generalised in data width and depth and adds programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow pulses, and a read-valid strobe. An optional first-word-fall-through read mode is available. It sits between same-clock producer/consumer blocks as the standard buffering primitive.

---
 rtl/param_fifo_pkg.sv | 19 +
 rtl/param_fifo_mem.sv | 26 ++
 rtl/param_sync_fifo.sv | 116 +++++++++++
 tb/tb_param_sync_fifo.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/param_fifo_pkg.sv
// Shared helpers for param_sync_fifo: pointer sizing, legality limits
// and default configuration values.
package param_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_AE_THRESH  = 2;
    localparam int MIN_DEPTH      = 4;

    // Pointer carries one extra wrap bit above the address.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= MIN_DEPTH) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// Register-array storage for param_sync_fifo: one synchronous write
// port and one asynchronous read port.
module param_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with thresholds, count and error pulses.
// Define PARAM_FIFO_FWFT_EN for first-word-fall-through read mode.
module param_sync_fifo
    import param_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = DEF_AE_THRESH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_en,
    input  logic [DATA_WIDTH-1:0]   i_data_in,
    input  logic                    i_rd_en,
    output logic [DATA_WIDTH-1:0]   o_data_out,
    output logic                    o_rd_valid,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_almost_full,
    output logic                    o_almost_empty,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_overflow,
    output logic                    o_underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    if (!depth_ok(DEPTH) || AF_THRESH < 1 || AF_THRESH > DEPTH ||
        AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_params
        $error("param_sync_fifo: illegal DEPTH or threshold");
    end

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // A pop frees the slot, so a write to a full FIFO may ride along.
    assign w_rd_acc = i_rd_en && !o_empty;
    assign w_wr_acc = i_wr_en && (!o_full || w_rd_acc);

    param_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (i_data_in),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= i_wr_en && !w_wr_acc;
            r_underflow <= i_rd_en && !w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count        = r_count;
    assign o_full         = (r_count == PW'(DEPTH));
    assign o_empty        = (r_count == '0);
    assign o_almost_full  = (r_count >= PW'(AF_THRESH));
    assign o_almost_empty = (r_count <= PW'(AE_THRESH));
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

`ifdef PARAM_FIFO_FWFT_EN
    assign o_data_out = w_rd_data;
    assign o_rd_valid = !o_empty;
`else
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_rd_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_out <= w_rd_data;
            end
        end
    end

    assign o_data_out = r_data_out;
    assign o_rd_valid = r_rd_valid;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo (DEPTH=16, AF=14, AE=2).
// Expectations adapt to the PARAM_FIFO_FWFT_EN read mode.
module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_errors = 0;

    param_sync_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (16),
        .AF_THRESH  (14),
        .AE_THRESH  (2)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wr_en        (wr_en),
        .i_data_in      (data_in),
        .i_rd_en        (rd_en),
        .o_data_out     (data_out),
        .o_rd_valid     (rd_valid),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (almost_full),
        .o_almost_empty (almost_empty),
        .o_count        (count),
        .o_overflow     (overflow),
        .o_underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input logic wr, input logic [7:0] d, input logic rd);
        wr_en   = wr;
        data_in = d;
        rd_en   = rd;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
`ifdef PARAM_FIFO_FWFT_EN
        check({tag, "_head"}, data_out, exp);
        check({tag, "_vld"}, rd_valid, 1'b1);
        step(1'b0, 8'h00, 1'b1);
`else
        step(1'b0, 8'h00, 1'b1);
        check({tag, "_data"}, data_out, exp);
        check({tag, "_vld"}, rd_valid, 1'b1);
`endif
    endtask

    initial begin
        // Reset then idle
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_ae", almost_empty, 1'b1);
        check("rst_count", count, 5'd0);
        check("rst_full", full, 1'b0);
        check("rst_af", almost_full, 1'b0);
        check("rst_rdv", rd_valid, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_udf", underflow, 1'b0);
`ifndef PARAM_FIFO_FWFT_EN
        check("rst_dout", data_out, 8'h00);
`endif

        // Fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 2) check("fill_ae2", almost_empty, 1'b1);
            if (i == 3) check("fill_ae3", almost_empty, 1'b0);
            if (i == 13) check("fill_af13", almost_full, 1'b0);
            if (i == 14) check("fill_af14", almost_full, 1'b1);
            if (i == 15) check("fill_full15", full, 1'b0);
        end
        check("fill_full", full, 1'b1);
        check("fill_count", count, 5'd16);
        step(1'b1, 8'hFF, 1'b0);
        check("ovf_pulse", overflow, 1'b1);
        check("ovf_count", count, 5'd16);
        step(1'b0, 8'h00, 1'b0);
        check("ovf_clear", overflow, 1'b0);

        // Drain 16
        for (int i = 1; i <= 16; i++) begin
            pop_chk("drain", 8'(i));
            check("drain_count", count, 5'(16 - i));
            if (i == 1) check("drain_full", full, 1'b0);
            if (i == 13) check("drain_ae13", almost_empty, 1'b0);
            if (i == 14) check("drain_ae14", almost_empty, 1'b1);
        end
        check("drain_empty", empty, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("udf_pulse", underflow, 1'b1);
        check("udf_rdv", rd_valid, 1'b0);
`ifndef PARAM_FIFO_FWFT_EN
        check("udf_hold", data_out, 8'h10);
`endif
        step(1'b0, 8'h00, 1'b0);
        check("udf_clear", underflow, 1'b0);

        // Pointer wrap
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 8; i++) pop_chk("wrapA", 8'(8'hA0 + i));
        for (int i = 0; i < 12; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        check("wrap_count", count, 5'd12);
        for (int i = 0; i < 12; i++) pop_chk("wrapC", 8'(8'hC0 + i));
        check("wrap_empty", empty, 1'b1);

        // Full with simultaneous write and read
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        check("fwr_full0", full, 1'b1);
`ifdef PARAM_FIFO_FWFT_EN
        check("fwr_head", data_out, 8'h30);
`endif
        step(1'b1, 8'h77, 1'b1);
        check("fwr_count", count, 5'd16);
        check("fwr_full", full, 1'b1);
        check("fwr_ovf", overflow, 1'b0);
`ifndef PARAM_FIFO_FWFT_EN
        check("fwr_data", data_out, 8'h30);
        check("fwr_rdv", rd_valid, 1'b1);
`endif
        for (int i = 1; i < 16; i++) pop_chk("fwr_drain", 8'(8'h30 + i));
        pop_chk("fwr_last", 8'h77);
        check("fwr_empty", empty, 1'b1);

        // Empty with simultaneous write and read
        step(1'b1, 8'h88, 1'b1);
        check("ewr_udf", underflow, 1'b1);
        check("ewr_count", count, 5'd1);
`ifdef PARAM_FIFO_FWFT_EN
        check("ewr_rdv", rd_valid, 1'b1);
`else
        check("ewr_rdv", rd_valid, 1'b0);
`endif
        pop_chk("ewr_pop", 8'h88);
        check("ewr_empty", empty, 1'b1);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        check("mrst_pre", count, 5'd5);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        check("mrst_count", count, 5'd0);
        check("mrst_empty", empty, 1'b1);
        check("mrst_rdv", rd_valid, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        check("mrst_wcount", count, 5'd1);
        pop_chk("mrst_pop", 8'h55);
        check("mrst_end", empty, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
